// File: rtl/ble_rx_pkg.sv
// Shared constants and state encoding for the BLE RX payload path.
// The TX CRC block uses the same CRC_W and POLY.
package ble_rx_pkg;
  localparam int CRC_W = 16;
  localparam int LEN_W = 14;
  localparam logic [CRC_W-1:0] POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DONE    = 2'd3
  } rx_state_e;
endpackage

// File: rtl/crc16_lfsr_ble.sv
// Serial MSB-first CRC-16 LFSR with synchronous seed load.
// It is shared by the payload and header check paths.
module crc16_lfsr_ble
  import ble_rx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CRC_W-1:0] i_seed,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = r_crc[CRC_W-1] ^ i_bit;
  assign o_crc = r_crc;

  // A seed load takes priority over a shift in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc <= '0;
    end else if (i_load) begin
      r_crc <= i_seed;
    end else if (i_en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/rx_payload_crc_check_bluetooth_ble.sv
// RX payload CRC checker: forwards payload bits, recomputes the CRC and
// compares it with the trailing 16 received CRC bits.
//
// state      | meaning
// IDLE       | after reset, waiting for start
// PAYLOAD    | forwarding payload bits and updating the CRC
// CHECK      | CRC frozen, comparing the 16 received CRC bits
// DONE       | result held until the next start
module rx_payload_crc_check_bluetooth_ble
  import ble_rx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid_in,
  input  logic             data_bit,
  input  logic [7:0]       uap_dci,
  input  logic [LEN_W-1:0] payload_len,
  output logic             data_out,
  output logic             valid_out,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [LEN_W-1:0] bits_rx
);

  rx_state_e        r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bits_rx;
  logic [3:0]       r_crc_cnt;
  logic             r_mismatch;
  logic             r_data_out;
  logic             r_valid_out;
  logic             r_done;
  logic             r_crc_ok;
  logic             r_crc_err;

  logic [CRC_W-1:0] w_crc;
  logic             w_acc_pay;
  logic [LEN_W-1:0] w_bits_nxt;
  logic             w_pay_last;
  logic             w_crc_last;
  logic             w_bit_mis;
  logic             w_mis_nxt;

  // Start wins over a bit arriving in the same cycle.
  assign w_acc_pay  = (r_state == ST_PAYLOAD) && valid_in && !start;
  assign w_bits_nxt = r_bits_rx + 1'b1;
  assign w_pay_last = (w_bits_nxt == r_len);
  assign w_crc_last = &r_crc_cnt;
  // Received bit k is checked against crc[15-k], i.e. crc[~k] for 4-bit k.
  assign w_bit_mis  = data_bit ^ w_crc[~r_crc_cnt];
  assign w_mis_nxt  = r_mismatch | w_bit_mis;

  crc16_lfsr_ble u_crc (
    .clk    (clk),
    .reset  (reset),
    .i_load (start),
    .i_seed ({8'h00, uap_dci}),
    .i_en   (w_acc_pay),
    .i_bit  (data_bit),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_bits_rx   <= '0;
      r_crc_cnt   <= '0;
      r_mismatch  <= 1'b0;
      r_data_out  <= 1'b0;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      if (start) begin
        r_state    <= (payload_len == '0) ? ST_CHECK : ST_PAYLOAD;
        r_len      <= payload_len;
        r_bits_rx  <= '0;
        r_crc_cnt  <= '0;
        r_mismatch <= 1'b0;
        r_crc_ok   <= 1'b0;
        r_crc_err  <= 1'b0;
      end else begin
        case (r_state)
          ST_PAYLOAD: begin
            if (valid_in) begin
              r_data_out  <= data_bit;
              r_valid_out <= 1'b1;
              r_bits_rx   <= w_bits_nxt;
              if (w_pay_last) r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (valid_in) begin
              r_crc_cnt  <= r_crc_cnt + 1'b1;
              r_mismatch <= w_mis_nxt;
              if (w_crc_last) begin
                r_state   <= ST_DONE;
                r_done    <= 1'b1;
                r_crc_ok  <= ~w_mis_nxt;
                r_crc_err <= w_mis_nxt;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign done      = r_done;
  assign crc_ok    = r_crc_ok;
  assign crc_err   = r_crc_err;
  assign bits_rx   = r_bits_rx;

endmodule

// File: tb/tb_rx_payload_crc_check_bluetooth_ble.sv
// Scoreboard bench for the BLE RX payload CRC checker.
module tb_rx_payload_crc_check_bluetooth_ble;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        valid_in;
  logic        data_bit;
  logic [7:0]  uap_dci;
  logic [13:0] payload_len;
  logic        data_out;
  logic        valid_out;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic [13:0] bits_rx;

  typedef struct {
    bit          ok;
    logic [13:0] bits;
  } res_t;

  bit   q_data[$];
  res_t q_res[$];
  int   checks = 0;
  int   errors = 0;
  bit   e_bit;
  res_t e_res;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  rx_payload_crc_check_bluetooth_ble dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .valid_in    (valid_in),
    .data_bit    (data_bit),
    .uap_dci     (uap_dci),
    .payload_len (payload_len),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .bits_rx     (bits_rx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_calc(input logic [7:0] seed, input bit pl[$]);
    logic [15:0] c;
    bit fb;
    c = {8'h00, seed};
    foreach (pl[i]) begin
      fb = c[15] ^ pl[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents data or a result.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (prev_done) chk("done_width", done, 1'b0);
      if (valid_out) begin
        if (q_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid_out: got data_out=%0b expected no output", data_out);
        end else begin
          e_bit = q_data.pop_front();
          chk("data_out", data_out, e_bit);
        end
      end
      if (done) begin
        if (q_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 crc_ok=%0b expected no done", crc_ok);
        end else begin
          e_res = q_res.pop_front();
          chk("crc_ok", crc_ok, e_res.ok);
          chk("crc_err", crc_err, !e_res.ok);
          chk("bits_rx", bits_rx, e_res.bits);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic cyc(input logic s, input logic v, input logic b);
    start = s; valid_in = v; data_bit = b;
    @(posedge clk); #1;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // abandon_at >= 0 stops after that many payload bits with no result expected.
  task automatic run_frame(input logic [7:0] seed, input int len, input bit pl[$],
                           input logic [15:0] crc, input bit gaps, input bit exp_ok,
                           input int abandon_at);
    int n;
    uap_dci = seed;
    payload_len = 14'(len);
    // A bit offered alongside start must be dropped.
    cyc(1'b1, 1'b1, 1'b1);
    if (abandon_at < 0) q_res.push_back('{exp_ok, 14'(len)});
    n = (abandon_at < 0) ? len : abandon_at;
    for (int i = 0; i < n; i++) begin
      gap(gaps);
      q_data.push_back(pl[i]);
      cyc(1'b0, 1'b1, pl[i]);
    end
    if (abandon_at < 0) begin
      for (int k = 0; k < 16; k++) begin
        gap(gaps);
        cyc(1'b0, 1'b1, crc[15-k]);
      end
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pl[$];
    bit pl2[$];
    bit big[$];
    logic [15:0] c;
    int w;

    reset = 1'b0; start = 1'b0; valid_in = 1'b0; data_bit = 1'b0;
    uap_dci = 8'h00; payload_len = '0;
    #3;
    chk("rst_data_out", data_out, 1'b0);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_crc_ok", crc_ok, 1'b0);
    chk("rst_crc_err", crc_err, 1'b0);
    chk("rst_bits_rx", bits_rx, 14'd0);
    #20 reset = 1'b1;
    @(posedge clk); #1;

    // Idle: stray bits without start must not be forwarded.
    repeat (3) cyc(1'b0, 1'b1, 1'b1);

    // len 1, payload '1', seed 0 -> CRC 0x1021
    pl = {1'b1};
    run_frame(8'h00, 1, pl, 16'h1021, 1'b0, 1'b1, -1);

    // Empty payload: CRC equals the seed
    pl = {};
    run_frame(8'h47, 0, pl, 16'h0047, 1'b0, 1'b1, -1);
    run_frame(8'h47, 0, pl, 16'h0046, 1'b0, 1'b0, -1);

    // DONE ignores further bits
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    chk("done_hold_ok", crc_ok, 1'b0);
    chk("done_hold_err", crc_err, 1'b1);

    // 240-bit random payload with gaps, then the same with one flipped bit
    pl = {};
    for (int i = 0; i < 240; i++) pl.push_back(1'($urandom_range(0, 1)));
    c = crc_calc(8'hA5, pl);
    run_frame(8'hA5, 240, pl, c, 1'b1, 1'b1, -1);
    pl2 = pl;
    pl2[37] = ~pl2[37];
    run_frame(8'hA5, 240, pl2, c, 1'b1, 1'b0, -1);

    // Abandon a 240-bit frame after 100 bits, then a full 8-bit frame
    run_frame(8'h5A, 240, pl, 16'h0000, 1'b1, 1'b0, 100);
    pl = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_frame(8'h33, 8, pl, crc_calc(8'h33, pl), 1'b1, 1'b1, -1);

    // Reset asserted mid-CHECK
    pl = {1'b0, 1'b1, 1'b0, 1'b1};
    uap_dci = 8'h12; payload_len = 14'd4;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      q_data.push_back(pl[i]);
      cyc(1'b0, 1'b1, pl[i]);
    end
    c = crc_calc(8'h12, pl);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, c[15-k]);
    chk("pre_rst_bits_rx", bits_rx, 14'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_data_out", data_out, 1'b0);
    chk("async_valid_out", valid_out, 1'b0);
    chk("async_done", done, 1'b0);
    chk("async_crc_ok", crc_ok, 1'b0);
    chk("async_crc_err", crc_err, 1'b0);
    chk("async_bits_rx", bits_rx, 14'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid_in = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    run_frame(8'h12, 4, pl, c, 1'b0, 1'b1, -1);

    // Maximum length frame, no counter wrap
    big = {};
    for (int i = 0; i < 16383; i++) big.push_back(1'($urandom_range(0, 1)));
    run_frame(8'h3C, 16383, big, crc_calc(8'h3C, big), 1'b0, 1'b1, -1);

    w = 0;
    while ((q_data.size() != 0 || q_res.size() != 0) && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("q_data_drained", q_data.size(), 0);
    chk("q_res_drained", q_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
